// File: rtl/proc_pkg.sv
// proc_pkg: shared types and defaults for the memory port arbiter
package proc_pkg;
  localparam int STARVE_LIMIT_DEF = 4;
  typedef enum logic [2:0] {IDLE, BUS_I, BUS_D, WAIT_I, WAIT_D} arb_state_t;
  typedef enum logic {OWNER_I, OWNER_D} mem_owner_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one req/gnt/rvalid memory port between fetch and data sides
module mem_arbiter
  import proc_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_rvalid_o,
  output logic        if_stall_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_be_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_rvalid_o,
  output logic        dm_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_owner_t       win;
  logic             bus_i, bus_d;
  // D normally wins; I wins once D has been granted LIMIT times in a row over a waiting I
  always_comb begin
    win = (dm_req_i && !(if_req_i && cnt_q == LIMIT)) ? OWNER_D : OWNER_I;
  end
  // next state and starvation counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (if_req_i || dm_req_i) begin
        state_d = (win == OWNER_D) ? BUS_D : BUS_I;
        cnt_d   = (win == OWNER_I) ? '0 : (if_req_i && cnt_q != LIMIT) ? cnt_q + CNT_W'(1) : cnt_q;
      end
      BUS_I:   state_d = mem_gnt_i ? WAIT_I : BUS_I;
      BUS_D:   state_d = mem_gnt_i ? WAIT_D : BUS_D;
      WAIT_I:  state_d = mem_rvalid_i ? IDLE : WAIT_I;
      WAIT_D:  state_d = mem_rvalid_i ? IDLE : WAIT_D;
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset abandons any transaction in flight
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus_i       = state_q == BUS_I;
  assign bus_d       = state_q == BUS_D;
  assign mem_req_o   = bus_i | bus_d;
  assign mem_we_o    = bus_d & dm_we_i;
  assign mem_be_o    = bus_d ? dm_be_i : bus_i ? 4'hF : 4'h0;
  assign mem_addr_o  = bus_d ? dm_addr_i : bus_i ? if_addr_i : 32'h0;
  assign mem_wdata_o = bus_d ? dm_wdata_i : 32'h0;
  assign if_rvalid_o = (state_q == WAIT_I) & mem_rvalid_i;
  assign dm_rvalid_o = (state_q == WAIT_D) & mem_rvalid_i;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
  assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : 32'h0;
  assign if_stall_o  = if_req_i & ~if_rvalid_o;
  assign dm_stall_o  = dm_req_i & ~dm_rvalid_o;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for the fetch/data memory arbiter
module tb_mem_arbiter;
  logic        clk_i = 0, rst_n_i = 0;
  logic        if_req_i = 0, dm_req_i = 0, dm_we_i = 0;
  logic [31:0] if_addr_i = 0, dm_addr_i = 0, dm_wdata_i = 0, mem_rdata_i = 0;
  logic [3:0]  dm_be_i = 0;
  logic        mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_rvalid_o, if_stall_o, dm_rvalid_o, dm_stall_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  int          n_chk = 0, n_fail = 0;

  mem_arbiter dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_rvalid_o(if_rvalid_o), .if_stall_o(if_stall_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_rvalid_o(dm_rvalid_o),
    .dm_stall_o(dm_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    #2;
    n_chk++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req_o); end
    n_chk++; if (if_rvalid_o !== 1'b0 || dm_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got if=%b dm=%b want 0 0", if_rvalid_o, dm_rvalid_o); end
    n_chk++; if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== 69'h0) begin n_fail++; $display("FAIL reset_fields: got we=%b be=%h addr=%h wd=%h want 0", mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
    cyc();
    rst_n_i = 1;
    cyc();
  endtask

  task automatic test_i_read;
    if_req_i = 1; if_addr_i = 32'h100;
    @(negedge clk_i);
    n_chk++; if (if_stall_o !== 1'b1 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL iread_c0: got stall=%b req=%b want 1 0", if_stall_o, mem_req_o); end
    cyc(); mem_gnt_i = 1;
    @(negedge clk_i);
    n_chk++; if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b0, 4'hF, 32'h100, 32'h0}) begin n_fail++; $display("FAIL iread_c1_bus: got req=%b we=%b be=%h addr=%h wd=%h want 1 0 f 100 0", mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
    n_chk++; if (if_stall_o !== 1'b1) begin n_fail++; $display("FAIL iread_c1_stall: got %b want 1", if_stall_o); end
    cyc(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    n_chk++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL iread_c2_resp: got v=%b d=%h want 1 deadbeef", if_rvalid_o, if_rdata_o); end
    n_chk++; if (if_stall_o !== 1'b0 || dm_rvalid_o !== 1'b0 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL iread_c2_misc: got stall=%b dmv=%b req=%b want 0 0 0", if_stall_o, dm_rvalid_o, mem_req_o); end
    cyc(); mem_rvalid_i = 0; if_req_i = 0;
    @(negedge clk_i);
    n_chk++; if (if_rvalid_o !== 1'b0 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL iread_c3_idle: got v=%b req=%b want 0 0", if_rvalid_o, mem_req_o); end
    cyc();
  endtask

  task automatic test_d_store;
    dm_req_i = 1; dm_we_i = 1; dm_be_i = 4'b0011; dm_addr_i = 32'h200; dm_wdata_i = 32'h1234;
    @(negedge clk_i);
    n_chk++; if (dm_stall_o !== 1'b1) begin n_fail++; $display("FAIL dst_c0_stall: got %b want 1", dm_stall_o); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk_i);
      n_chk++; if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 4'h3, 32'h200, 32'h1234}) begin n_fail++; $display("FAIL dst_hold%0d: got req=%b we=%b be=%h addr=%h wd=%h want 1 1 3 200 1234", i, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
    end
    cyc(); mem_gnt_i = 1;
    @(negedge clk_i);
    n_chk++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL dst_gnt_req: got %b want 1", mem_req_o); end
    cyc(); mem_gnt_i = 0;
    @(negedge clk_i);
    n_chk++; if (mem_req_o !== 1'b0 || dm_rvalid_o !== 1'b0 || dm_stall_o !== 1'b1) begin n_fail++; $display("FAIL dst_wait: got req=%b v=%b stall=%b want 0 0 1", mem_req_o, dm_rvalid_o, dm_stall_o); end
    cyc(); mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE;
    @(negedge clk_i);
    n_chk++; if (dm_rvalid_o !== 1'b1 || dm_rdata_o !== 32'hCAFE || if_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL dst_resp: got dmv=%b d=%h ifv=%b want 1 cafe 0", dm_rvalid_o, dm_rdata_o, if_rvalid_o); end
    cyc(); mem_rvalid_i = 0; dm_req_i = 0; dm_we_i = 0;
    @(negedge clk_i);
    n_chk++; if (dm_rvalid_o !== 1'b0 || dm_rdata_o !== 32'h0) begin n_fail++; $display("FAIL dst_pulse: got v=%b d=%h want 0 0", dm_rvalid_o, dm_rdata_o); end
    cyc();
  endtask

  task automatic test_simultaneous;
    if_req_i = 1; if_addr_i = 32'h300; dm_req_i = 1; dm_we_i = 0; dm_be_i = 4'hF; dm_addr_i = 32'h400;
    cyc(); mem_gnt_i = 1;
    @(negedge clk_i);
    n_chk++; if (mem_addr_o !== 32'h400 || if_stall_o !== 1'b1) begin n_fail++; $display("FAIL sim_first: got addr=%h stall=%b want 400 1", mem_addr_o, if_stall_o); end
    cyc(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h11;
    @(negedge clk_i);
    n_chk++; if (dm_rvalid_o !== 1'b1 || dm_rdata_o !== 32'h11 || if_rvalid_o !== 1'b0 || if_stall_o !== 1'b1) begin n_fail++; $display("FAIL sim_dresp: got dmv=%b d=%h ifv=%b stall=%b want 1 11 0 1", dm_rvalid_o, dm_rdata_o, if_rvalid_o, if_stall_o); end
    cyc(); mem_rvalid_i = 0; dm_req_i = 0;
    @(negedge clk_i);
    n_chk++; if (mem_req_o !== 1'b0 || if_stall_o !== 1'b1) begin n_fail++; $display("FAIL sim_idle: got req=%b stall=%b want 0 1", mem_req_o, if_stall_o); end
    cyc(); mem_gnt_i = 1;
    @(negedge clk_i);
    n_chk++; if (mem_addr_o !== 32'h300 || mem_be_o !== 4'hF || if_stall_o !== 1'b1) begin n_fail++; $display("FAIL sim_second: got addr=%h be=%h stall=%b want 300 f 1", mem_addr_o, mem_be_o, if_stall_o); end
    cyc(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h22;
    @(negedge clk_i);
    n_chk++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h22) begin n_fail++; $display("FAIL sim_iresp: got v=%b d=%h want 1 22", if_rvalid_o, if_rdata_o); end
    cyc(); mem_rvalid_i = 0; if_req_i = 0;
    cyc();
  endtask

  task automatic test_starvation;
    logic [31:0] exp_addr [6] = '{32'h600, 32'h600, 32'h600, 32'h600, 32'h500, 32'h600};
    if_req_i = 1; if_addr_i = 32'h500; dm_req_i = 1; dm_addr_i = 32'h600;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      n_chk++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL starve_idle%0d: got req=%b want 0", k, mem_req_o); end
      cyc(); mem_gnt_i = 1;
      @(negedge clk_i);
      n_chk++; if (mem_addr_o !== exp_addr[k]) begin n_fail++; $display("FAIL starve_owner%0d: got addr=%h want %h", k, mem_addr_o, exp_addr[k]); end
      cyc(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h40 + k;
      @(negedge clk_i);
      n_chk++; if ({if_rvalid_o, dm_rvalid_o} !== ((exp_addr[k] == 32'h500) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL starve_strobe%0d: got if=%b dm=%b", k, if_rvalid_o, dm_rvalid_o); end
      cyc(); mem_rvalid_i = 0;
    end
    if_req_i = 0; dm_req_i = 0;
    cyc();
  endtask

  task automatic test_spurious;
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h77; if_req_i = 1; if_addr_i = 32'h700;
    @(negedge clk_i);
    n_chk++; if (if_rvalid_o !== 1'b0 || dm_rvalid_o !== 1'b0 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL spur_idle: got ifv=%b dmv=%b req=%b want 0 0 0", if_rvalid_o, dm_rvalid_o, mem_req_o); end
    cyc(); mem_gnt_i = 0;
    @(negedge clk_i);
    n_chk++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h700 || if_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL spur_bus1: got req=%b addr=%h v=%b want 1 700 0", mem_req_o, mem_addr_o, if_rvalid_o); end
    cyc();
    @(negedge clk_i);
    n_chk++; if (mem_req_o !== 1'b1 || if_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL spur_bus2: got req=%b v=%b want 1 0", mem_req_o, if_rvalid_o); end
    cyc(); mem_rvalid_i = 0; mem_gnt_i = 1;
    cyc(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h78;
    @(negedge clk_i);
    n_chk++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h78) begin n_fail++; $display("FAIL spur_resp: got v=%b d=%h want 1 78", if_rvalid_o, if_rdata_o); end
    cyc(); mem_rvalid_i = 0; if_req_i = 0;
    cyc();
  endtask

  task automatic test_reset_mid;
    dm_req_i = 1; dm_we_i = 0; dm_be_i = 4'hF; dm_addr_i = 32'h800;
    cyc(); mem_gnt_i = 1;
    cyc(); mem_gnt_i = 0;
    rst_n_i = 0;
    #1;
    n_chk++; if (mem_req_o !== 1'b0 || dm_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got req=%b v=%b want 0 0", mem_req_o, dm_rvalid_o); end
    cyc(); rst_n_i = 1; dm_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h99;
    @(negedge clk_i);
    n_chk++; if (dm_rvalid_o !== 1'b0 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_late: got v=%b req=%b want 0 0", dm_rvalid_o, mem_req_o); end
    cyc(); mem_rvalid_i = 0; dm_req_i = 1; dm_addr_i = 32'h900;
    cyc(); mem_gnt_i = 1;
    @(negedge clk_i);
    n_chk++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h900) begin n_fail++; $display("FAIL rstmid_bus: got req=%b addr=%h want 1 900", mem_req_o, mem_addr_o); end
    cyc(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hAB;
    @(negedge clk_i);
    n_chk++; if (dm_rvalid_o !== 1'b1 || dm_rdata_o !== 32'hAB) begin n_fail++; $display("FAIL rstmid_resp: got v=%b d=%h want 1 ab", dm_rvalid_o, dm_rdata_o); end
    cyc(); mem_rvalid_i = 0; dm_req_i = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_store();
    test_simultaneous();
    test_starvation();
    test_spurious();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between the fetch stage (I-side) and the memory stage (D-side, loads/stores).
- Sequences one transaction at a time onto the memory bus using a req/gnt/rvalid handshake.
- Returns responses to the requester that owns the transaction.
- Drives per-side stall signals that the pipeline control logic ORs into its stall.

Parameters:
- STARVE_LIMIT, 4: max consecutive D grants issued while the I-side waits; the next grant then goes to I.
- CNT_W, 3: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_rvalid_o
- if_addr_i  in  32  fetch address
- if_rdata_o  out  32  fetch read data
- if_rvalid_o  out  1  fetch response strobe, one cycle
- if_stall_o  out  1  fetch waiting
- dm_req_i  in  1  data request; held stable until dm_rvalid_o
- dm_we_i  in  1  1 = store
- dm_be_i  in  4  byte enables
- dm_addr_i  in  32  data address
- dm_wdata_i  in  32  store data
- dm_rdata_o  out  32  load data
- dm_rvalid_o  out  1  data response strobe, one cycle; also pulses for stores
- dm_stall_o  out  1  data access waiting
- mem_req_o  out  1  bus request, held until mem_gnt_i
- mem_we_o  out  1  bus write
- mem_be_o  out  4  bus byte enables
- mem_addr_o  out  32  bus address
- mem_wdata_o  out  32  bus write data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  response; arrives at least 1 cycle after gnt, one outstanding
- mem_rdata_i  in  32  response data

Behaviour:
- Clock and reset:
  - One clock, clk_i.
  - Reset is asynchronous and active-low on rst_n_i.
  - Reset forces state IDLE and clears the starvation counter.
  - Reset values: mem_req_o=0, if_rvalid_o=0, dm_rvalid_o=0, mem_* fields 0.
- States are IDLE, BUS_I, BUS_D, WAIT_I, WAIT_D.
- IDLE:
  - Arbitrates on the current if_req_i/dm_req_i.
  - The winner moves to BUS_x on the next cycle; with no request, stay in IDLE.
  - D wins when dm_req_i=1, unless if_req_i=1 and counter==STARVE_LIMIT; then I wins.
- BUS_x:
  - mem_req_o=1, mem_* fields driven from owner x's inputs; I-side drives we=0, be=4'hF, wdata=0.
  - On mem_gnt_i=1, go to WAIT_x next cycle.
  - Without a grant, hold with fields stable.
- WAIT_x:
  - mem_req_o=0.
  - On mem_rvalid_i=1, x_rvalid_o=1 in the same cycle (combinational); x_rdata_o=mem_rdata_i that cycle, else 0.
  - Return to IDLE next cycle.
- Minimum latency, request to response, is 3 cycles: req seen in IDLE (c0), BUS with gnt (c1), WAIT with rvalid (c2).
- Stalls: if_stall_o = if_req_i & ~if_rvalid_o; dm_stall_o = dm_req_i & ~dm_rvalid_o.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each IDLE->BUS_D transition taken while if_req_i=1.
  - Clears on IDLE->BUS_I.
  - Holds otherwise.
- Boundary conditions:
  - mem_rvalid_i in IDLE or BUS_x is ignored: no strobe, no state change.
  - mem_gnt_i outside BUS_x is ignored.
  - A requester dropping req while in BUS_x/WAIT_x is a protocol error. The arbiter completes the transaction and still pulses the strobe.
  - Reset mid-transaction abandons it. A late mem_rvalid_i after reset is ignored by the IDLE rule.
  - Both requests in IDLE with counter < STARVE_LIMIT: D wins; I stays stalled.

Decomposition:
- proc_pkg gets:
  - arb_state_t enum (IDLE, BUS_I, BUS_D, WAIT_I, WAIT_D)
  - mem_owner_t enum (OWNER_I, OWNER_D)
  - the default STARVE_LIMIT constant
- Single module; no sub-module. The priority pick is a small combinational block inside mem_arbiter.

Test Plan:
- I-only read: if_req_i=1, addr 0x100, gnt at c1, rvalid with data 0xDEADBEEF at c2 -> mem_addr_o=0x100, we=0, be=F at c1; if_rvalid_o=1, if_rdata_o=0xDEADBEEF at c2; if_stall_o=1 for c0-c1.
- D store with delayed gnt: dm_we_i=1, be=4'b0011, addr 0x200, wdata 0x1234, gnt after 3 BUS cycles -> mem_req_o/fields held stable 3 cycles; dm_rvalid_o single pulse on rvalid; no if_rvalid_o.
- Simultaneous requests, counter=0: both req at c0 -> BUS_D first; I granted only after D's response; if_stall_o stays 1 throughout.
- Starvation: dm_req_i continuously re-asserted, if_req_i=1, STARVE_LIMIT=4 -> exactly 4 D transactions, then 1 I transaction, counter cleared.
- Spurious bus events: mem_rvalid_i=1 in IDLE and in BUS_I -> no rvalid strobes, state unchanged; mem_gnt_i=1 in IDLE -> ignored.
- Reset mid-WAIT_D: rst_n_i low for 1 cycle, then mem_rvalid_i arrives -> mem_req_o=0 immediately on reset; no dm_rvalid_o; arbiter in IDLE and grants the next request normally.
